// File: rtl/demux_feed_pkg.sv
// Shared types and constants for the nibble demux feeder.
// An entry packs the destination channel above the data nibble.
package demux_feed_pkg;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

    typedef struct packed {
        logic [SEL_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: the head entry is visible on rd_data whenever not empty.
// A pop does not free space for a same-cycle push when full (no pass-through).
module sync_fifo_sa #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int FW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [FW-1:0]    fill,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (fill == FW'(DEPTH));
    assign empty   = (fill == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                fill <= fill + 1'b1;
            end else if (do_pop && !do_push) begin
                fill <= fill - 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_feed_scheduler.sv
// Feeds buffered {dest,data} words to a 1-to-4 nibble demux and counts deliveries per channel.
// While idle the data is forced to zero and the select holds the last-used channel.
module demux_feed_scheduler
    import demux_feed_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    localparam int FW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_dest,
    input  logic               out_en,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_s1,
    output logic               out_s0,
    output logic [FW-1:0]      fill,
    output logic [4*CNT_W-1:0] chan_sent
);

    entry_t           wr_entry;
    entry_t           head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [SEL_W-1:0] last_sel;
    logic [CNT_W-1:0] cnt [4];

    assign wr_entry  = '{dest: in_dest, data: in_data};
    assign in_ready  = !rst && !full;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_en;

    sync_fifo_sa #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .fill    (fill),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        out_data         = '0;
        {out_s1, out_s0} = last_sel;
        if (out_valid) begin
            out_data         = head.data;
            {out_s1, out_s0} = head.dest;
        end
    end

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sel <= CH_A;
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= '0;
            end
        end else if (pop) begin
            last_sel        <= head.dest;
            cnt[head.dest]  <= cnt[head.dest] + 1'b1;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_pack
        assign chan_sent[k*CNT_W +: CNT_W] = cnt[k];
    end

endmodule

// File: tb/tb_demux_feed_scheduler.sv
// Self-checking bench: a queue-based model checked every cycle, plus literal spot checks.
module tb_demux_feed_scheduler;
    import demux_feed_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = '0;
    logic [1:0]  in_dest = '0;
    logic        out_en = 1'b0;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_s1;
    logic        out_s0;
    logic [2:0]  fill;
    logic [31:0] chan_sent;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    entry_t     mq[$];
    int         mcnt[4];
    logic [1:0] mlast;

    demux_feed_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_en    (out_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_s1    (out_s1),
        .out_s0    (out_s0),
        .fill      (fill),
        .chan_sent (chan_sent)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue with per-channel tallies.
    always @(posedge clk) begin
        entry_t e;
        bit acc;
        if (rst) begin
            mq.delete();
            for (int k = 0; k < 4; k++) mcnt[k] = 0;
            mlast = 2'b00;
            model_on = 1'b1;
        end else begin
            acc = in_valid && (mq.size() != DEPTH);
            if (out_en && mq.size() != 0) begin
                e = mq.pop_front();
                mcnt[e.dest] = (mcnt[e.dest] + 1) % 256;
                mlast = e.dest;
            end
            if (acc) begin
                e.dest = in_dest;
                e.data = in_data;
                mq.push_back(e);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic        ev;
        logic [3:0]  ed;
        logic [1:0]  es;
        logic [31:0] ec;
        if (model_on) begin
            ev = (mq.size() != 0);
            ed = ev ? mq[0].data : 4'h0;
            es = ev ? mq[0].dest : mlast;
            ec = {8'(mcnt[3]), 8'(mcnt[2]), 8'(mcnt[1]), 8'(mcnt[0])};
            checkOutput("m_in_ready", 32'(in_ready), 32'(!rst && mq.size() != DEPTH));
            checkOutput("m_out_valid", 32'(out_valid), 32'(ev));
            checkOutput("m_out_data", 32'(out_data), 32'(ed));
            checkOutput("m_sel", 32'({out_s1, out_s0}), 32'(es));
            checkOutput("m_fill", 32'(fill), 32'(mq.size()));
            checkOutput("m_chan_sent", chan_sent, ec);
        end
    end

    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic [1:0] dst, input logic en);
        in_valid = v;
        in_data  = d;
        in_dest  = dst;
        out_en   = en;
        @(posedge clk);
        #2;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        $display("[TB] start");
        resetDut();
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b0);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_data", 32'(out_data), 32'd0);
        checkOutput("idle_sel", 32'({out_s1, out_s0}), 32'd0);
        checkOutput("idle_fill", 32'(fill), 32'd0);
        checkOutput("idle_cnt", chan_sent, 32'd0);

        // Single word to channel c.
        applyStimulus(1'b1, 4'hA, CH_C, 1'b0);
        checkOutput("one_valid", 32'(out_valid), 32'd1);
        checkOutput("one_data", 32'(out_data), 32'hA);
        checkOutput("one_sel", 32'({out_s1, out_s0}), 32'b10);
        checkOutput("one_fill", 32'(fill), 32'd1);
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b1);
        checkOutput("one_pop_valid", 32'(out_valid), 32'd0);
        checkOutput("one_pop_data", 32'(out_data), 32'd0);
        checkOutput("one_pop_sel", 32'({out_s1, out_s0}), 32'b10);
        checkOutput("one_pop_cnt", chan_sent, 32'h0001_0000);

        // Fill to capacity, then hold a fifth word until space opens.
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 1), 2'(i), 1'b0);
        checkOutput("full_fill", 32'(fill), 32'd4);
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 4'hF, CH_D, 1'b0);
        applyStimulus(1'b1, 4'hF, CH_D, 1'b0);
        checkOutput("held_fill", 32'(fill), 32'd4);
        checkOutput("held_head", 32'(out_data), 32'h1);
        applyStimulus(1'b1, 4'hF, CH_D, 1'b1);
        checkOutput("full_pop_fill", 32'(fill), 32'd3);
        checkOutput("full_pop_head", 32'(out_data), 32'h2);
        applyStimulus(1'b1, 4'hF, CH_D, 1'b1);
        checkOutput("pushpop_fill", 32'(fill), 32'd3);
        checkOutput("pushpop_head", 32'(out_data), 32'h3);
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b1);
        checkOutput("drain_4", 32'(out_data), 32'h4);
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b1);
        checkOutput("drain_F", 32'(out_data), 32'hF);
        checkOutput("drain_F_sel", 32'({out_s1, out_s0}), 32'b11);
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b1);
        checkOutput("drain_empty", 32'(out_valid), 32'd0);
        checkOutput("drain_cnt", chan_sent, 32'h0201_0101);

        // Streaming with simultaneous push and pop; pointers wrap repeatedly.
        resetDut();
        applyStimulus(1'b1, 4'h1, CH_B, 1'b1);
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b1, 4'(i + 1), (i % 2) ? CH_D : CH_B, 1'b1);
            checkOutput("stream_fill", 32'(fill), 32'd1);
            checkOutput("stream_data", 32'(out_data), 32'(i + 1));
        end
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b1);
        checkOutput("stream_cnt", chan_sent, 32'h0500_0500);

        // Counter wrap on channel a.
        resetDut();
        for (int i = 0; i < 257; i++) applyStimulus(1'b1, 4'(i), CH_A, 1'b1);
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b1);
        checkOutput("wrap_cnt", chan_sent, 32'h0000_0001);
        checkOutput("wrap_fill", 32'(fill), 32'd0);

        // Reset mid-stream discards buffered words.
        resetDut();
        applyStimulus(1'b1, 4'h7, CH_B, 1'b0);
        applyStimulus(1'b1, 4'h8, CH_C, 1'b0);
        applyStimulus(1'b1, 4'h9, CH_D, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_fill", 32'(fill), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_cnt", chan_sent, 32'd0);
        applyStimulus(1'b1, 4'h5, CH_B, 1'b0);
        checkOutput("post_rst_data", 32'(out_data), 32'h5);
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'h0, 2'd0, 1'b1);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("post_rst_cnt", chan_sent, 32'h0000_0100);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_feed_scheduler.md
Name: demux_feed_scheduler

Overview:
- Upstream feeder for the 1-to-4 nibble demultiplexer.
- Accepts {destination, 4-bit data} words over a valid/ready handshake and buffers them in a small FIFO.
- Presents the head word to the demux as data plus select lines {s1,s0}, advancing on a downstream enable.
- Keeps per-channel delivery counters for debug and throughput checks.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of each per-channel delivery counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  4  nibble to route.
- in_dest  in  2  destination channel: 0=a, 1=b, 2=c, 3=d.
- out_en  in  1  consumer accepts the presented word this cycle.
- out_valid  out  1  out_data/select carry a real word.
- out_data  out  4  drives demux data input.
- out_s1  out  1  demux select MSB.
- out_s0  out  1  demux select LSB.
- fill  out  clog2(DEPTH+1)  current FIFO occupancy.
- chan_sent  out  4*CNT_W  packed counters; chan_sent[k*CNT_W +: CNT_W] counts words delivered to channel k.

Behaviour:
- One clock, synchronous active-high reset. The reset has priority over all other activity.
- Reset values:
  - fill=0, pointers=0.
  - out_valid=0, out_data=4'h0, {out_s1,out_s0}=2'b00.
  - all chan_sent fields=0, stored last_sel=2'b00.
  - in_ready=0 while rst is high.
- in_ready = !rst && (fill != DEPTH).
  - There is no pass-through when full: a pop in the same cycle does not free space for a push that cycle.
- Push: in_valid && in_ready at a clock edge writes {in_dest,in_data} at wr_ptr, and wr_ptr increments modulo DEPTH.
  - in_data/in_dest are ignored when in_valid=0.
- Show-ahead output:
  - out_valid = (fill != 0).
  - out_data = head data when out_valid, else 4'h0.
  - {out_s1,out_s0} = head dest when out_valid, else last_sel.
  - While idle the demux therefore routes zero to the last-used channel, so all demux outputs are 0.
- Latency: a word pushed at edge N into an empty FIFO is presented in the cycle after edge N (1 cycle).
- Pop: out_valid && out_en at an edge:
  - rd_ptr increments modulo DEPTH.
  - last_sel <= head dest.
  - chan_sent[head dest] increments, wrapping from 2^CNT_W-1 to 0.
  - out_en is ignored when out_valid=0.
- Simultaneous push and pop (fill between 1 and DEPTH-1): fill is unchanged, and both pointers advance.
- Push into empty with out_en=1: no pop that cycle; the word appears the next cycle.
- Full: in_ready=0. An in_valid word is held upstream, with no loss and no overwrite.
- Ordering is strictly FIFO regardless of destination. There is no reordering or per-channel bypass.
- Pointer wrap: after DEPTH pushes/pops the pointers return to 0; data order is preserved across the wrap.
- Reset mid-operation: all buffered words are discarded, counters clear, and out_valid drops in the cycle after the reset edge.
- No state machine beyond FIFO occupancy; fill ranges over 0..DEPTH.

Decomposition:
- Shared package demux_feed_pkg holds:
  - channel constants CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3.
  - DATA_W=4, SEL_W=2.
  - the entry typedef packing {dest[1:0], data[3:0]}.
- One sub-module, sync_fifo_sa:
  - parameterised width/depth, show-ahead, synchronous active-high reset.
  - exposes fill/full/empty.
- The top level adds output zeroing, last_sel and the counters.

Test Plan:
- Reset then idle:
  - during reset: in_ready=0.
  - after reset: in_ready=1, out_valid=0, out_data=0, sel=00, fill=0, all chan_sent=0.
- Push {dest=2,data=A} with out_en=0:
  - the next cycle shows out_valid=1, out_data=A, {s1,s0}=10, fill=1.
  - with out_en=1 for one cycle, the next cycle shows out_valid=0, out_data=0, sel=10, chan_sent[2]=1.
- Push 4 words (dest 0..3, data 1,2,3,4) with out_en=0:
  - fill=4, in_ready=0.
  - a 5th word (data F) is held until one pop.
  - then drain with out_en=1 and check the order 1,2,3,4,F with correct selects, and each chan_sent=1 (chan_sent[3]=2 if F targets d).
- Continuous streaming, in_valid=1 and out_en=1, 10 words alternating dest 1/3:
  - fill stays at 1, with one word delivered per cycle.
  - pointers wrap correctly, with no drop or duplicate.
  - chan_sent[1]=5, chan_sent[3]=5.
- With CNT_W=8, push 257 words to dest 0 and deliver all:
  - chan_sent[0]=1 (wrapped), other counters 0.
- Fill 3 words, assert rst for one cycle mid-stream:
  - fill=0, out_valid=0, counters 0.
  - previously buffered words never appear afterwards.
